// File: rtl/dgs_code_sched.sv
// Diagnostic blink-code scheduler: rotates latched faults onto one LED as pulse bursts plus a dark gap.
// Latency: FAULT at edge k -> LOAD k+1 -> BLINK k+2 -> LED_OUT high from k+3; no backpressure, faults latch until CLEAR.
// Optional DGS_SCHED_PRIO_EN: lowest pending index always wins instead of round-robin.
module dgs_code_sched #(
  parameter int FREQ_HZ    = 100000000,
  parameter int PULSE_US   = 1,
  parameter int NUM_SRC    = 4,
  parameter int CODE_W     = 3,
  parameter int GAP_QUANTS = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_SRC-1:0]           FAULT,
  input  logic [NUM_SRC-1:0]           CLEAR,
  input  logic [NUM_SRC*CODE_W-1:0]    CODE_TABLE,
  output logic                         LED_OUT,
  output logic [$clog2(NUM_SRC)-1:0]   ACTIVE_IDX,
  output logic                         BUSY,
  output logic                         FRAME_DONE
);

  localparam int PULSE = (FREQ_HZ / 1000000) * PULSE_US;
  localparam int QUANT = 2 * PULSE;
  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (QUANT > 2) ? $clog2(QUANT) : 1;
  localparam int GQ_W  = (GAP_QUANTS > 1) ? $clog2(GAP_QUANTS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUANT - 1);
  localparam logic [CNT_W-1:0] PULSE_C  = CNT_W'(PULSE);
  localparam logic [GQ_W-1:0]  GQ_LAST  = GQ_W'(GAP_QUANTS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BLINK,
    ST_GAP
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NUM_SRC-1:0]  pending;
  logic [CNT_W-1:0]    cntr;
  logic [CODE_W-1:0]   blink_cnt;
  logic [GQ_W-1:0]     gap_q;
  logic [IDX_W-1:0]    last_idx;
  logic [IDX_W-1:0]    sel;
  logic                sel_vld;
  logic                quant_end;
  logic                frame_end;
  logic [CODE_W-1:0]   load_code;
  logic [CODE_W-1:0]   code_arr [NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_code
    assign code_arr[g] = CODE_TABLE[g*CODE_W +: CODE_W];
  end

  // ACTIVE_IDX is already updated when LOAD runs, so it indexes the table directly.
  assign load_code = code_arr[ACTIVE_IDX];
  assign sel_vld   = |pending;
  assign quant_end = (cntr == CNT_LAST);
  assign BUSY      = (state != ST_IDLE);

`ifdef DGS_SCHED_PRIO_EN
  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[IDX_W'(i)]) sel = IDX_W'(i);
    end
  end
`else
  // Scan from farthest to nearest so the first pending index after last_idx wins.
  always_comb begin
    int j;
    j   = 0;
    sel = '0;
    for (int off = NUM_SRC; off >= 1; off--) begin
      j = int'(last_idx) + off;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (pending[IDX_W'(j)]) sel = IDX_W'(j);
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    frame_end = 1'b0;
    case (state)
      ST_IDLE:  if (sel_vld) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = (load_code != '0) ? ST_BLINK : ST_GAP;
      ST_BLINK: if (quant_end && blink_cnt == CODE_W'(1)) state_nxt = ST_GAP;
      ST_GAP: begin
        if (quant_end && gap_q == GQ_LAST) begin
          state_nxt = ST_IDLE;
          frame_end = 1'b1;
        end
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      pending    <= '0;
      cntr       <= '0;
      blink_cnt  <= '0;
      gap_q      <= '0;
      last_idx   <= IDX_LAST;
      ACTIVE_IDX <= '0;
      LED_OUT    <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state   <= state_nxt;
      // A set in the same clock as a clear wins, so a 1-clock fault is never dropped.
      pending <= FAULT | (pending & ~CLEAR);

      if (state == ST_BLINK || state == ST_GAP) cntr <= quant_end ? '0 : cntr + 1'b1;
      else                                      cntr <= '0;

      if (state == ST_IDLE && sel_vld) ACTIVE_IDX <= sel;

      if (state == ST_LOAD) begin
        blink_cnt <= load_code;
        gap_q     <= '0;
      end else if (state == ST_BLINK && quant_end) begin
        blink_cnt <= blink_cnt - 1'b1;
      end else if (state == ST_GAP && quant_end) begin
        gap_q <= (gap_q == GQ_LAST) ? '0 : gap_q + 1'b1;
      end

      if (frame_end) last_idx <= ACTIVE_IDX;

      LED_OUT    <= (state == ST_BLINK) && (cntr < PULSE_C);
      FRAME_DONE <= frame_end;
    end
  end

endmodule
